dram_responder: RTL and testbench
=================================

Name: dram_responder

Overview:
- Memory-end responder for the cache's memory-side bus; behavioural DRAM model for simulation and integration.
- Accepts a line read request through the reqcyc/reqack handshake.
- Waits a fixed access latency, then returns one 64-byte line as 8 data beats over the respcyc/respack handshake, echoing the request tag.
- A preload port writes the storage array directly, without using the bus.

Parameters:
- BUS_DATA_WIDTH, 64: data and address width.
- BUS_TAG_WIDTH, 13: request/response tag width.
- MEM_WORDS, 1024: storage depth in BUS_DATA_WIDTH-bit words; power of two.
- LATENCY, 4: idle cycles between the ACK cycle and the first response beat; 0 is legal.
- BEATS, 8: data beats per line.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high.
- bus_reqcyc  in  1  request valid from the cache.
- bus_reqack  out  1  request accepted (one-cycle pulse).
- bus_req  in  BUS_DATA_WIDTH  byte address of the request.
- bus_reqtag  in  BUS_TAG_WIDTH  request tag.
- bus_respcyc  out  1  response beat valid.
- bus_respack  in  1  cache has taken the current beat.
- bus_resp  out  BUS_DATA_WIDTH  beat data.
- bus_resptag  out  BUS_TAG_WIDTH  tag captured with the request.
- init_we  in  1  preload write enable.
- init_addr  in  $clog2(MEM_WORDS)  preload word index.
- init_data  in  BUS_DATA_WIDTH  preload data.

Behaviour:
- Reset:
  - Asserting reset forces state to IDLE immediately, from any state, including mid-burst; any in-flight request is discarded.
  - Outputs under reset: bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0; beat pointer and latency counter = 0.
  - Storage is NOT cleared by reset.
- States: IDLE, ACK, WAIT, SEND.
- IDLE:
  - If bus_reqcyc=1 at posedge: capture line base = bus_req with the low 6 bits cleared, capture bus_reqtag, go to ACK.
  - Otherwise stay in IDLE.
- ACK:
  - bus_reqack=1 for exactly this one cycle; bus_reqack is a registered output.
  - Next state is WAIT with counter=LATENCY, or SEND directly if LATENCY=0.
  - bus_reqcyc is ignored in every state except IDLE; the requester must drop it after seeing bus_reqack.
- WAIT:
  - Counter decrements each cycle.
  - When counter=1, go to SEND.
  - First beat therefore appears LATENCY+1 cycles after the ACK cycle begins.
- SEND:
  - bus_respcyc=1, bus_resptag=captured tag.
  - bus_resp = mem[(base>>3 + ptr) mod MEM_WORDS]; word index wraps at the top of the array.
  - bus_resp is read combinationally from the array using the registered ptr.
  - bus_respack=1 at posedge: beat accepted, ptr increments.
  - bus_respack=0: hold ptr; data and tag stay stable.
  - Beat BEATS-1 accepted: ptr returns to 0, state returns to IDLE, bus_respcyc=0 in the next cycle.
- Outside SEND: bus_resp=0 and bus_respcyc=0. bus_resptag holds its last captured value.
- Throughput: a new request can be captured in IDLE the cycle after the last beat is accepted.
  - Minimum request-to-request spacing is 1+1+LATENCY+BEATS cycles.
- Preload port:
  - init_we=1 writes init_data to mem[init_addr] at posedge, in any state, and also while reset is asserted.
  - If the preload hits the word currently on bus_resp, the new value is visible in the following cycle.
- Unaligned bus_req: the low 6 bits are ignored. The burst always starts at the line base; there is no critical-word-first ordering.

Test Plan:
- Basic read:
  - Stimulus: preload mem[8..15]=0x100..0x107; request addr 0x40, tag 0x5; respack held at 1.
  - Required: reqack pulses 1 cycle; first respcyc LATENCY+1 cycles later; beats 0x100..0x107 on 8 consecutive cycles, resptag=0x5; then respcyc=0.
- Back-pressure:
  - Stimulus: same request; respack low for 3 cycles on beat 2.
  - Required: bus_resp holds 0x102 and respcyc stays 1 through the stall; total burst takes 11 cycles.
- Unaligned address and wrap:
  - Stimulus: request 0x7F9 with MEM_WORDS=1024.
  - Required: beats come from words 0xF8..0xFF.
  - Stimulus: request 0x1FFC0.
  - Required: beats come from words 0x3F8..0x3FF; then request 0x2000 returns words 0..7.
- reqcyc held high through a burst:
  - Stimulus: bus_reqcyc remains 1 during ACK, WAIT and SEND.
  - Required: only one reqack; a second reqack appears only after beat 7 is accepted and IDLE resamples.
- Reset mid-burst:
  - Stimulus: assert reset asynchronously after beat 3.
  - Required: respcyc=0 and resp=0 immediately; after release, idle with no reqack; memory contents unchanged on the next read.
- LATENCY=0 build:
  - Stimulus: single request.
  - Required: first beat valid in the cycle right after the ACK cycle.

Source files
------------

// File: rtl/dram_responder.sv
// Behavioural DRAM responder: accepts one line read, waits a fixed latency,
// then streams the line back as BEATS data beats with the request tag echoed.
module dram_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 1024,
    parameter int LATENCY        = 4,
    parameter int BEATS          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bus_reqcyc,
    output logic                         bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
    output logic                         bus_respcyc,
    input  logic                         bus_respack,
    output logic [BUS_DATA_WIDTH-1:0]    bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [BUS_DATA_WIDTH-1:0]    init_data,
    output logic [1:0]                   o_dbg_state
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW = $clog2(LATENCY + 2);
    localparam bit ZERO_LAT = (LATENCY == 0);

    // Handshake: a request is taken on the posedge where IDLE sees bus_reqcyc=1
    // and bus_reqack answers for one cycle; a beat is taken on each posedge
    // where bus_respcyc and bus_respack are both 1, otherwise the beat holds.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [BUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    logic [AW-1:0]             r_base;
    logic [BUS_TAG_WIDTH-1:0]  r_tag;
    logic [PW-1:0]             r_ptr;
    logic [CW-1:0]             r_cnt;
    logic                      r_reqack;

    logic [AW-1:0] w_req_word;
    logic [AW-1:0] w_word;
    logic          w_last_beat;
    logic          w_send;

    // Line base with the low 6 address bits dropped, as a word index.
    assign w_req_word  = AW'((bus_req & ~BUS_DATA_WIDTH'(6'h3F)) >> 3);
    assign w_word      = r_base + AW'(r_ptr);
    assign w_last_beat = (r_ptr == PW'(BEATS - 1));
    assign w_send      = (r_state == S_SEND);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus_reqcyc) w_next = S_ACK;
            S_ACK:  w_next = ZERO_LAT ? S_SEND : S_WAIT;
            S_WAIT: if (r_cnt == CW'(1)) w_next = S_SEND;
            S_SEND: if (bus_respack && w_last_beat) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_tag    <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_reqack <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_reqack <= (w_next == S_ACK);
            if (r_state == S_IDLE && bus_reqcyc) begin
                r_base <= w_req_word;
                r_tag  <= bus_reqtag;
            end
            if (r_state == S_ACK) begin
                r_cnt <= CW'(LATENCY);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_send && bus_respack) begin
                r_ptr <= w_last_beat ? '0 : r_ptr + PW'(1);
            end
        end
    end

    // Storage is deliberately outside the reset domain so preloads survive reset.
    always_ff @(posedge clk) begin
        if (init_we) begin
            r_mem[init_addr] <= init_data;
        end
    end

    assign bus_reqack  = r_reqack;
    assign bus_respcyc = w_send;
    assign bus_resp    = w_send ? r_mem[w_word] : '0;
    assign bus_resptag = r_tag;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares every accepted beat.
module tb_dram_responder;

    localparam int W   = 64;
    localparam int T   = 13;
    localparam int MW  = 1024;
    localparam int LAT = 4;
    localparam int NB  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [W-1:0]  bus_req, bus_resp, init_data;
    logic [T-1:0]  bus_reqtag, bus_resptag;
    logic          init_we;
    logic [9:0]    init_addr;
    logic [1:0]    dbg_state;

    logic          z_reqcyc, z_reqack, z_respcyc, z_respack;
    logic [W-1:0]  z_req, z_resp, z_init_data;
    logic [T-1:0]  z_reqtag, z_resptag;
    logic          z_init_we;
    logic [9:0]    z_init_addr;
    logic [1:0]    z_dbg;

    logic [W-1:0]   tb_mem [MW];
    logic [T+W-1:0] exp_q [$];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dram_responder #(.LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .o_dbg_state(dbg_state)
    );

    dram_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .bus_reqcyc(z_reqcyc), .bus_reqack(z_reqack),
        .bus_req(z_req), .bus_reqtag(z_reqtag),
        .bus_respcyc(z_respcyc), .bus_respack(z_respack),
        .bus_resp(z_resp), .bus_resptag(z_resptag),
        .init_we(z_init_we), .init_addr(z_init_addr), .init_data(z_init_data),
        .o_dbg_state(z_dbg)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pat(input int w);
        if (w >= 8 && w < 16) return 64'h100 + 64'(w - 8);
        return 64'hCAFE_0000_0000_0000 | 64'(w);
    endfunction

    // Accepted-beat monitor.
    always @(negedge clk) begin
        if (!reset && bus_respcyc && bus_respack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", bus_resp, 64'hDEAD);
            end else begin
                logic [T+W-1:0] e;
                e = exp_q.pop_front();
                check("beat_data", bus_resp, e[W-1:0]);
                check("beat_tag", 64'(bus_resptag), 64'(e[T+W-1:W]));
            end
        end
    end

    task automatic push_line(input logic [T-1:0] tag, input int w0);
        for (int i = 0; i < NB; i++) exp_q.push_back({tag, tb_mem[(w0 + i) % MW]});
    endtask

    task automatic run_burst(input logic [W-1:0] addr, input logic [T-1:0] tag, input int w0,
                             input bit hold, input int stall_beat, input int stall_len,
                             input int abort_at);
        int lat, j, beat, st, extra;
        push_line(tag, w0);
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b1;
        tick();
        check("reqack_pulse", 64'(bus_reqack), 64'd1);
        if (!hold) bus_reqcyc = 1'b0;
        lat = 0; extra = 0;
        while (!bus_respcyc && lat < 20) begin
            tick(); lat++;
            extra += int'(bus_reqack);
        end
        check("first_beat_latency", 64'(lat), 64'(LAT + 1));
        j = 0; beat = 0; st = 0;
        while (bus_respcyc && j < 40) begin
            if (beat == abort_at) begin
                #1 reset = 1'b1;
                #1;
                check("rst_respcyc", 64'(bus_respcyc), 64'd0);
                check("rst_resp", bus_resp, 64'd0);
                check("rst_resptag", 64'(bus_resptag), 64'd0);
                check("rst_state", 64'(dbg_state), 64'd0);
                exp_q.delete();
                tick(); tick();
                reset = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    check("post_rst_reqack", 64'(bus_reqack), 64'd0);
                    check("post_rst_respcyc", 64'(bus_respcyc), 64'd0);
                end
                return;
            end
            extra += int'(bus_reqack);
            if (beat == stall_beat && st < stall_len) begin
                check("stall_resp", bus_resp, tb_mem[(w0 + beat) % MW]);
                bus_respack = 1'b0;
                st++;
            end else begin
                bus_respack = 1'b1;
                beat++;
            end
            j++;
            tick();
        end
        bus_respack = 1'b1;
        check("burst_cycles", 64'(j), 64'(NB + stall_len));
        check("respcyc_low_after", 64'(bus_respcyc), 64'd0);
        check("no_extra_reqack", 64'(extra), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b1;
        bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b1;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        z_reqcyc = 1'b0; z_req = '0; z_reqtag = '0; z_respack = 1'b1;
        z_init_we = 1'b0; z_init_addr = '0; z_init_data = '0;
        tick();
        // Preload both arrays while reset is held.
        for (int i = 0; i < MW; i++) begin
            init_we = 1'b1; init_addr = 10'(i); init_data = pat(i);
            tb_mem[i] = pat(i);
            z_init_we = (i < 8); z_init_addr = 10'(i); z_init_data = 64'h200 + 64'(i);
            tick();
        end
        init_we = 1'b0; z_init_we = 1'b0;
        check("reset_reqack", 64'(bus_reqack), 64'd0);
        check("reset_respcyc", 64'(bus_respcyc), 64'd0);
        check("reset_resp", bus_resp, 64'd0);
        check("reset_resptag", 64'(bus_resptag), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        tick(); tick();

        run_burst(64'h40, 13'h5, 8, 1'b0, -1, 0, -1);
        run_burst(64'h40, 13'h5, 8, 1'b0, 2, 3, -1);
        run_burst(64'h7F9, 13'h1A, 'hF8, 1'b0, -1, 0, -1);
        run_burst(64'h1FFC0, 13'h1FFF, 'h3F8, 1'b0, -1, 0, -1);
        run_burst(64'h2000, 13'h3, 0, 1'b0, -1, 0, -1);

        // reqcyc held high: second ack only once IDLE resamples.
        run_burst(64'h40, 13'h77, 8, 1'b1, -1, 0, -1);
        push_line(13'h77, 8);
        check("held_idle_no_ack", 64'(bus_reqack), 64'd0);
        tick();
        check("held_second_ack", 64'(bus_reqack), 64'd1);
        bus_reqcyc = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin tick(); guard++; end
        tick();
        check("held_drain", 64'(exp_q.size()), 64'd0);

        run_burst(64'h80, 13'h44, 16, 1'b0, -1, 0, 4);
        run_burst(64'h80, 13'h45, 16, 1'b0, -1, 0, -1);

        // Zero-latency instance: first beat in the cycle after ACK.
        z_reqcyc = 1'b1; z_req = 64'h3F; z_reqtag = 13'h9;
        tick();
        check("z_reqack", 64'(z_reqack), 64'd1);
        z_reqcyc = 1'b0;
        tick();
        check("z_first_respcyc", 64'(z_respcyc), 64'd1);
        check("z_tag", 64'(z_resptag), 64'h9);
        for (int i = 0; i < NB; i++) begin
            check("z_beat", z_resp, 64'h200 + 64'(i));
            tick();
        end
        check("z_respcyc_low", 64'(z_respcyc), 64'd0);

        tick(); tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
